// File: rtl/hub75_capture.sv
// Purpose: rebuilds pixels from a sampled HUB75 connector (shift/latch/bit-plane) and streams them to a frame buffer.
// Latency: first wr_valid 2 cycles after the completing latch edge is detected; then 1 pixel/cycle.
// Backpressure: wr_* held while wr_valid && !wr_ready; a row completing while emit is busy is dropped (ovf_err).
//
// Ports:
//   display_clock, resetn           sample clock, async active-low reset
//   panel_{r,g,b}{0,1}, panel_a..e  colour bits (top/bottom half) and row select {e,d,c,b,a}
//   panel_clk, panel_stb, panel_oe  shift clock, latch strobe, output enable (unused)
//   wr_valid/wr_ready/wr_addr/wr_data  pixel write stream, addr = {y, x}, data = {R,G,B}
//   frame_done, len_err, ovf_err    end-of-frame pulse, sticky line-length and overflow errors
module hub75_capture #(
    parameter int HEIGHT       = 64,
    parameter int WIDTH        = 64,
    parameter int CHAIN_LENGTH = 1,
    parameter int COLOR_DEPTH  = 8
) (
    input  logic display_clock,
    input  logic resetn,
    input  logic panel_r0,
    input  logic panel_g0,
    input  logic panel_b0,
    input  logic panel_r1,
    input  logic panel_g1,
    input  logic panel_b1,
    input  logic panel_a,
    input  logic panel_b,
    input  logic panel_c,
    input  logic panel_d,
    input  logic panel_e,
    input  logic panel_clk,
    input  logic panel_stb,
    input  logic panel_oe,
    output logic wr_valid,
    input  logic wr_ready,
    output logic [$clog2(HEIGHT)+$clog2(WIDTH*CHAIN_LENGTH)-1:0] wr_addr,
    output logic [23:0] wr_data,
    output logic frame_done,
    output logic len_err,
    output logic ovf_err
);

    localparam int L    = WIDTH * CHAIN_LENGTH;
    localparam int XW   = $clog2(L);
    localparam int YW   = $clog2(HEIGHT);
    localparam int CW   = $clog2(L + 1);
    localparam int PW   = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int SCAN = HEIGHT / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TOP  = 2'd1;
    localparam logic [1:0] S_BOT  = 2'd2;

    // Output enable only gates brightness on the panel; nothing to rebuild from it.
    logic unused_oe;
    assign unused_oe = panel_oe;

    // ---------------------------------------------------------------
    // Input synchroniser: bit 12 stb, 11 clk, 10:6 row, 5:0 {r1,g1,b1,r0,g0,b0}.
    // Data and strobes travel through the same flops so they stay aligned.
    // ---------------------------------------------------------------
    logic [12:0] sync1, sync2;
    logic        clk_d, stb_d;

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            clk_d <= 1'b0;
            stb_d <= 1'b0;
        end else begin
            sync1 <= {panel_stb, panel_clk, panel_e, panel_d, panel_c, panel_b, panel_a,
                      panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0};
            sync2 <= sync1;
            clk_d <= sync2[11];
            stb_d <= sync2[12];
        end
    end

    logic       clk_rise, stb_rise;
    logic [4:0] row_in;
    logic [5:0] pix_in;
    assign clk_rise = sync2[11] & ~clk_d;
    assign stb_rise = sync2[12] & ~stb_d;
    assign row_in   = sync2[10:6];
    assign pix_in   = sync2[5:0];

    // ---------------------------------------------------------------
    // Capture side
    // ---------------------------------------------------------------
    logic [CW-1:0] x_cnt;
    logic [PW-1:0] plane_cnt, plane_next;
    logic [4:0]    last_row;
    logic          first_latch;
    logic          pend;           // completed row waiting to be copied to obuf
    logic [1:0]    state;
    logic          emit_busy, row_done;

    // A repeated row advances the plane; a new row, the first latch, or a
    // wrap past the last plane restarts at plane 0.
    always_comb begin
        plane_next = '0;
        if (!(first_latch || (row_in != last_row) || (plane_cnt == PW'(COLOR_DEPTH - 1))))
            plane_next = plane_cnt + 1'b1;
    end

    assign row_done  = stb_rise && (plane_next == PW'(COLOR_DEPTH - 1));
    assign emit_busy = (state != S_IDLE) || pend;

    // Shift write index: a shift edge coinciding with a latch is x=0 of the next line.
    logic          shift_wr;
    logic [XW-1:0] shift_idx;
    always_comb begin
        shift_wr  = 1'b0;
        shift_idx = '0;
        if (clk_rise) begin
            if (stb_rise) begin
                shift_wr = 1'b1;
            end else if (x_cnt < CW'(L)) begin
                shift_wr  = 1'b1;
                shift_idx = x_cnt[XW-1:0];
            end
        end
    end

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            x_cnt       <= '0;
            plane_cnt   <= '0;
            last_row    <= '0;
            first_latch <= 1'b1;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
            pend        <= 1'b0;
        end else begin
            if (stb_rise) begin
                if (x_cnt != CW'(L))
                    len_err <= 1'b1;
                last_row    <= row_in;
                plane_cnt   <= plane_next;
                first_latch <= 1'b0;
                x_cnt       <= clk_rise ? CW'(1) : '0;
            end else if (clk_rise) begin
                if (x_cnt < CW'(L))
                    x_cnt <= x_cnt + 1'b1;
                else
                    len_err <= 1'b1;
            end

            if (row_done && emit_busy)
                ovf_err <= 1'b1;

            if (row_done && !emit_busy)
                pend <= 1'b1;
            else if (state == S_IDLE)
                pend <= 1'b0;
        end
    end

    // Pixel storage: no reset needed, every bit is rewritten before it is emitted.
    logic [5:0]                  stage [L];
    logic [5:0][COLOR_DEPTH-1:0] accum [L];
    logic [5:0][COLOR_DEPTH-1:0] obuf  [L];
    logic                        load_obuf;
    assign load_obuf = (state == S_IDLE) && pend;

    always_ff @(posedge display_clock) begin
        if (stb_rise) begin
            for (int x = 0; x < L; x++)
                for (int c = 0; c < 6; c++)
                    accum[x][c][plane_next] <= stage[x][c];
        end
        if (shift_wr)
            stage[shift_idx] <= pix_in;
        // The final plane lands in accum on the latch cycle, so the copy
        // happens one cycle later (no latch can arrive in between).
        if (load_obuf)
            obuf <= accum;
    end

    // ---------------------------------------------------------------
    // Emit side
    // ---------------------------------------------------------------
    logic [XW-1:0]  ex;            // x of the pixel currently presented
    logic [4:0]     orow;
    logic           nx_bot;
    logic [XW-1:0]  nx_x;
    logic [YW-1:0]  nx_y;
    logic [5:0][COLOR_DEPTH-1:0] nx_entry;
    logic [7:0]     nx_r, nx_g, nx_b;

    // Next pixel to present: the current index if nothing is shown yet,
    // otherwise the successor of the pixel being accepted.
    always_comb begin
        nx_bot = (state == S_BOT);
        nx_x   = ex;
        if (wr_valid) begin
            if (ex == XW'(L - 1)) begin
                nx_bot = 1'b1;
                nx_x   = '0;
            end else begin
                nx_x = ex + 1'b1;
            end
        end
        nx_entry = obuf[nx_x];
        nx_r = nx_bot ? 8'(nx_entry[5]) : 8'(nx_entry[2]);
        nx_g = nx_bot ? 8'(nx_entry[4]) : 8'(nx_entry[1]);
        nx_b = nx_bot ? 8'(nx_entry[3]) : 8'(nx_entry[0]);
        nx_y = YW'(orow) + (nx_bot ? YW'(SCAN) : YW'(0));
    end

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ex         <= '0;
            orow       <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        state <= S_TOP;
                        ex    <= '0;
                        orow  <= last_row;
                    end
                end
                S_TOP, S_BOT: begin
                    if (!wr_valid) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= {nx_y, nx_x};
                        wr_data  <= {nx_r, nx_g, nx_b};
                    end else if (wr_ready) begin
                        if (state == S_BOT && ex == XW'(L - 1)) begin
                            state      <= S_IDLE;
                            wr_valid   <= 1'b0;
                            frame_done <= (orow == 5'(SCAN - 1));
                        end else begin
                            wr_addr <= {nx_y, nx_x};
                            wr_data <= {nx_r, nx_g, nx_b};
                            ex      <= nx_x;
                            if (ex == XW'(L - 1))
                                state <= S_BOT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
module tb_hub75_capture;

    localparam int H    = 64;
    localparam int W    = 64;
    localparam int CL   = 1;
    localparam int CD   = 8;
    localparam int L    = W * CL;
    localparam int SCAN = H / 2;

    logic display_clock = 1'b0;
    logic resetn = 1'b0;
    logic panel_r0 = 0, panel_g0 = 0, panel_b0 = 0;
    logic panel_r1 = 0, panel_g1 = 0, panel_b1 = 0;
    logic panel_a = 0, panel_b = 0, panel_c = 0, panel_d = 0, panel_e = 0;
    logic panel_clk = 0, panel_stb = 0, panel_oe = 0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [11:0] wr_addr;
    logic [23:0] wr_data;
    logic        frame_done, len_err, ovf_err;

    hub75_capture #(.HEIGHT(H), .WIDTH(W), .CHAIN_LENGTH(CL), .COLOR_DEPTH(CD)) dut (
        .display_clock(display_clock), .resetn(resetn),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_a(panel_a), .panel_b(panel_b), .panel_c(panel_c), .panel_d(panel_d), .panel_e(panel_e),
        .panel_clk(panel_clk), .panel_stb(panel_stb), .panel_oe(panel_oe),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .len_err(len_err), .ovf_err(ovf_err)
    );

    always #5 display_clock = ~display_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [11:0] a; logic [23:0] d; } wr_t;
    wr_t  exp_q[$];
    logic [5:0] stage_m [L];
    int   acc_m [L][6];          // per pixel, per channel: colour value built from planes
    int   xcnt_m, last_row_m, pc_m;
    bit   first_m, len_m, ovf_m;
    int   col [L][6];            // colour the driver is sending, per pixel and channel
    logic [5:0] line_buf [0:79];

    // ---------------- sink / monitor ----------------
    int ready_mode = 0;          // 0 always, 1 one-in-three, 2 never, 3 random
    int cyc = 0;
    int acc_cnt = 0;
    int fd_cnt = 0;
    logic [11:0] last_acc = '0;

    always @(negedge display_clock) begin
        cyc++;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = (cyc % 3 == 0);
            2:       wr_ready = 1'b0;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
        if (resetn && wr_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 32'(wr_valid), 0);
            end else begin
                check("wr_addr", 32'(wr_addr), 32'(exp_q[0].a));
                check("wr_data", 32'(wr_data), 32'(exp_q[0].d));
                if (wr_ready) begin
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    last_acc = wr_addr;
                end
            end
        end
        if (resetn && frame_done) begin
            fd_cnt++;
            check("fd_after_last", 32'(last_acc), 32'((H - 1) * L + (L - 1)));
        end
    end

    task automatic model_reset();
        first_m = 1; pc_m = 0; xcnt_m = 0; last_row_m = 0;
        len_m = 0; ovf_m = 0;
        exp_q.delete();
    endtask

    task automatic model_latch(input int row);
        int p;
        wr_t w;
        if (first_m || row != last_row_m || pc_m == CD - 1) p = 0;
        else p = pc_m + 1;
        if (xcnt_m != L) len_m = 1;
        for (int x = 0; x < L; x++)
            for (int c = 0; c < 6; c++)
                if (stage_m[x][c]) acc_m[x][c] = acc_m[x][c] | (1 << p);
                else               acc_m[x][c] = acc_m[x][c] & ~(1 << p);
        last_row_m = row; pc_m = p; first_m = 0; xcnt_m = 0;
        if (p == CD - 1) begin
            if (exp_q.size() != 0) begin
                ovf_m = 1;
            end else begin
                for (int h = 0; h < 2; h++)
                    for (int x = 0; x < L; x++) begin
                        w.a = 12'((row + h * SCAN) * L + x);
                        w.d = 24'((acc_m[x][3*h+2] << 16) | (acc_m[x][3*h+1] << 8) | acc_m[x][3*h]);
                        exp_q.push_back(w);
                    end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            {panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0} = line_buf[i];
            panel_clk = 1'b0;
            @(negedge display_clock);
            panel_clk = 1'b1;
            @(negedge display_clock);
            if (xcnt_m < L) begin
                stage_m[xcnt_m] = line_buf[i];
                xcnt_m++;
            end else begin
                len_m = 1;
            end
        end
    endtask

    task automatic latch(input int row);
        logic [4:0] r;
        r = 5'(row);
        {panel_e, panel_d, panel_c, panel_b, panel_a} = r;
        panel_clk = 1'b0;
        panel_stb = 1'b1;
        @(negedge display_clock);
        panel_stb = 1'b0;
        repeat (3) @(negedge display_clock);
        model_latch(row);
    endtask

    // Sends planes 0..np-1 of col[][] for one row; plane sp uses a line of sl clocks.
    task automatic send_row(input int row, input int np, input int sp, input int sl, input bit chk_lat);
        int n;
        for (int p = 0; p < np; p++) begin
            n = (p == sp) ? sl : L;
            for (int x = 0; x < n; x++) begin
                if (x < L) begin
                    for (int c = 0; c < 6; c++) line_buf[x][c] = 1'((col[x][c] >> p) & 1);
                end else begin
                    line_buf[x] = 6'($urandom);
                end
            end
            send_line(n);
            latch(row);
        end
        if (chk_lat) begin
            check("lat_before", 32'(wr_valid), 0);
            @(negedge display_clock);
            check("lat_first", 32'(wr_valid), 1);
        end
    endtask

    task automatic fill_random();
        for (int x = 0; x < L; x++)
            for (int c = 0; c < 6; c++) col[x][c] = int'($urandom_range(0, 255));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge display_clock);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        repeat (4) @(negedge display_clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_len_err", 32'(len_err), 0);
        check("rst_ovf_err", 32'(ovf_err), 0);
        model_reset();
        repeat (2) @(negedge display_clock);
        resetn = 1'b1;
        @(negedge display_clock);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge display_clock);
        check("rst_valid", 32'(wr_valid), 0);
        check("rst_addr", 32'(wr_addr), 0);
        check("rst_data", 32'(wr_data), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_len", 32'(len_err), 0);
        check("rst_ovf", 32'(ovf_err), 0);
        resetn = 1'b1;
        @(negedge display_clock);

        // Single pixel on row 3, with first-pixel latency check.
        for (int x = 0; x < L; x++) for (int c = 0; c < 6; c++) col[x][c] = 0;
        col[5][2] = 8'hA5;
        acc_cnt = 0;
        send_row(3, CD, -1, L, 1);
        wait_drain(600);
        check("single_cnt", 32'(acc_cnt), 128);
        check("single_len", 32'(len_err), 0);
        check("single_ovf", 32'(ovf_err), 0);

        // Same row again (plane wraps), random colours, random ready.
        ready_mode = 3;
        fill_random();
        acc_cnt = 0;
        send_row(3, CD, -1, L, 0);
        wait_drain(1000);
        check("rand_cnt", 32'(acc_cnt), 128);

        // Full frame of a ramp pattern.
        ready_mode = 0;
        acc_cnt = 0;
        fd_cnt = 0;
        for (int r = 0; r < SCAN; r++) begin
            for (int x = 0; x < L; x++)
                for (int c = 0; c < 6; c++) col[x][c] = (x * 3 + r * 5 + c * 41) & 255;
            send_row(r, CD, -1, L, 0);
        end
        wait_drain(1000);
        check("frame_cnt", 32'(acc_cnt), 32'(SCAN * 2 * L));
        check("frame_done_cnt", 32'(fd_cnt), 1);
        check("frame_len", 32'(len_err), 0);

        // Backpressure: ready one cycle in three.
        ready_mode = 1;
        fill_random();
        acc_cnt = 0;
        send_row(20, CD, -1, L, 0);
        wait_drain(2000);
        check("bp_cnt", 32'(acc_cnt), 128);
        check("bp_ovf", 32'(ovf_err), 0);
        ready_mode = 0;

        // Short line (60 clocks) on plane 3.
        do_reset();
        fill_random();
        acc_cnt = 0;
        send_row(6, CD, 3, 60, 0);
        wait_drain(1000);
        check("short_len", 32'(len_err), 1);
        check("short_len_m", 32'(len_err), 32'(len_m));
        check("short_cnt", 32'(acc_cnt), 128);

        // Long line (70 clocks) on plane 5.
        do_reset();
        fill_random();
        acc_cnt = 0;
        send_row(6, CD, 5, 70, 0);
        wait_drain(1000);
        check("long_len", 32'(len_err), 1);
        check("long_cnt", 32'(acc_cnt), 128);

        // Overflow: second row completes while the first is stalled.
        do_reset();
        ready_mode = 2;
        fill_random();
        acc_cnt = 0;
        send_row(9, CD, -1, L, 0);
        fill_random();
        send_row(10, CD, -1, L, 0);
        check("ovf_err", 32'(ovf_err), 1);
        check("ovf_err_m", 32'(ovf_err), 32'(ovf_m));
        ready_mode = 0;
        wait_drain(1000);
        repeat (200) @(negedge display_clock);
        check("ovf_cnt", 32'(acc_cnt), 128);

        // Row change mid-row: row 2 is abandoned, row 7 is emitted.
        do_reset();
        fill_random();
        acc_cnt = 0;
        send_row(2, 4, -1, L, 0);
        fill_random();
        send_row(7, CD, -1, L, 0);
        wait_drain(1000);
        check("rowchg_cnt", 32'(acc_cnt), 128);
        check("rowchg_len", 32'(len_err), 0);

        // Asynchronous reset in the middle of an emit.
        fill_random();
        send_row(12, CD, -1, L, 0);
        repeat (20) @(negedge display_clock);
        check("mid_valid_before", 32'(wr_valid), 1);
        do_reset();
        acc_cnt = 0;
        repeat (300) @(negedge display_clock);
        check("post_rst_valid", 32'(wr_valid), 0);
        check("post_rst_cnt", 32'(acc_cnt), 0);
        fill_random();
        send_row(1, CD, -1, L, 0);
        wait_drain(1000);
        check("post_rst_row_cnt", 32'(acc_cnt), 128);
        check("final_len", 32'(len_err), 0);
        check("final_ovf", 32'(ovf_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receiving end of the HUB75 panel interface. It samples a panel connector driven by the panel driver or an upstream cube node.
- Rebuilds per-pixel colour values from the row-address / bit-plane / shift / latch sequence.
- Emits reconstructed pixels as a write stream into a frame buffer.
- Used for loopback checking of the panel driver and for daisy-chained cube nodes.

Parameters:
- HEIGHT, 64: panel rows. Scan rows = HEIGHT/2.
- WIDTH, 64: pixels per panel row.
- CHAIN_LENGTH, 1: panels in chain. Line length L = WIDTH*CHAIN_LENGTH.
- COLOR_DEPTH, 8: bit planes per scan row, LSB plane first.

Ports:
- display_clock  in  1  sample clock; must be at least 2x the panel_clk toggle rate.
- resetn  in  1  asynchronous, active-low reset.
- panel_r0, panel_g0, panel_b0  in  1 each  top-half colour bits.
- panel_r1, panel_g1, panel_b1  in  1 each  bottom-half colour bits.
- panel_a, panel_b, panel_c, panel_d, panel_e  in  1 each  row select; {e,d,c,b,a} is the row, a is the LSB.
- panel_clk  in  1  shift clock; data captured on its rising edge.
- panel_stb  in  1  latch, active high.
- panel_oe  in  1  ignored; not captured.
- wr_valid  out  1  pixel write valid.
- wr_ready  in  1  sink accepts the write.
- wr_addr  out  clog2(HEIGHT)+clog2(L)  {y, x}.
- wr_data  out  24  {R,G,B}; each channel is 8 bits, COLOR_DEPTH value zero-extended in the channel LSBs.
- frame_done  out  1  one-cycle pulse after the last pixel of scan row HEIGHT/2-1 is accepted.
- len_err  out  1  sticky.
- ovf_err  out  1  sticky.

Behaviour:
- Input sync: all panel inputs pass through a 2-flop synchroniser. Edge detection runs on the synchronised panel_clk and panel_stb.
- Shift capture: on each synchronised panel_clk rising edge with x_cnt < L:
  - stage[x_cnt] <= {r1,g1,b1,r0,g0,b0};
  - x_cnt++.
  - Edges with x_cnt >= L set len_err and are otherwise ignored.
  - The first edge after a latch is pixel x=0.
- Latch: on a synchronised panel_stb rising edge:
  - row = {e,d,c,b,a}.
  - If row != last_row, or this is the first latch after reset: plane = 0. Otherwise plane = plane_cnt+1.
  - If x_cnt != L, set len_err. The transfer still proceeds.
  - Copy all L stage entries into bit [plane] of accum in one cycle. accum holds 6 channels x COLOR_DEPTH bits per x.
  - Update last_row <= row and plane_cnt <= plane. Clear x_cnt.
  - If plane reaches COLOR_DEPTH-1 (which also covers plane_cnt wrap past COLOR_DEPTH-1): copy accum and row to the output buffer, then start emit.
  - If the emit FSM is not IDLE at that point, drop the new row and set ovf_err.
- Emit FSM states:
  - IDLE: waits for a row completion, then goes to TOP.
  - TOP: emits x = 0..L-1 with y = row and the top-half channels.
  - BOT: emits x = 0..L-1 with y = row + HEIGHT/2 and the bottom-half channels.
  - TOP -> BOT after x = L-1 is accepted. BOT -> IDLE after x = L-1 is accepted.
  - frame_done pulses on the cycle after the BOT -> IDLE transition when row == HEIGHT/2-1.
- Valid/ready handshake:
  - wr_valid, wr_addr and wr_data are registered and held stable while wr_valid && !wr_ready.
  - The next pixel is presented the cycle after acceptance, so throughput is 1 pixel/cycle with ready held high.
- Latency: the first wr_valid appears 2 cycles after the final latch edge is detected internally.
- Simultaneous shift edge and stb edge in one cycle: the latch is processed first, then the shift edge is captured as x=0 of the next line.
- Capture and emit are independent. Shifting of the next row proceeds while emit runs.
- Reset (asynchronous, any time, including mid-emit):
  - wr_valid = 0, frame_done = 0, len_err = 0, ovf_err = 0, wr_addr = 0, wr_data = 0.
  - x_cnt = 0, plane_cnt = 0, "first latch" flag set, FSM = IDLE.
  - stage and accum contents are don't-care.
- Errors are cleared only by reset.

Test Plan:
- Loopback, single pixel: driver-style sequence for row 3 with all COLOR_DEPTH planes, top x=5 R bits 0xA5, others 0. Required: 128 writes; addr {3,5} data 0xA50000; every other top pixel 0; bottom-half addrs {35,x} all 0; no errors.
- Full frame: 32 rows x 8 planes of a ramp pattern, wr_ready=1. Required: 4096 writes with correct values; frame_done pulses exactly once, after addr {63,63}.
- Backpressure: wr_ready toggles 1-of-3 cycles mid-emit. Required: wr_addr/wr_data stable while stalled; no pixel lost or duplicated; ovf_err = 0.
- Short line: 60 clocks then stb. Required: len_err = 1; x 60..63 hold prior stage data. Line of 70 clocks: len_err = 1; extra 6 bits ignored.
- Overflow: wr_ready = 0 held while a second row completes. Required: ovf_err = 1; only the first row is emitted once ready = 1.
- Row change mid-row: 4 planes on row 2, then latch on row 7. Required: plane resets to 0; row 2 is never emitted; row 7 is emitted after 8 planes. Async resetn pulse mid-emit: wr_valid drops to 0 immediately, and no writes occur until new latches arrive.
